// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
//   state_t    : scan FSM states
//   key_code_t : {row[1:0], col[1:0]}
//   low_row()  : index of the lowest-numbered active-low row
package keypad_pkg;

  localparam int ROWS = 4;
  localparam int COLS = 4;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, RELEASE} state_t;
  typedef logic [3:0] key_code_t;

  // Rows are active-low; row 0 wins when several are pressed.
  function automatic logic [1:0] low_row(input logic [ROWS-1:0] rs);
    logic [1:0] r;
    r = 2'd0;
    for (int i = ROWS-1; i >= 0; i--)
      if (!rs[i]) r = 2'(i);
    return r;
  endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// Two-flop synchronizer, resets to all-ones (idle level of pulled-up rows).
//   clk, nrst : clock, async active-low reset
//   d         : asynchronous input
//   q         : synchronized output
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s1;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      s1 <= '1;
      q  <= '1;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with press/release debounce and a one-entry
// valid/ready holding register.
//   clk, nrst   : clock, async active-low reset
//   en          : block enable; low = synchronous clear, columns tri-stated
//   row_in      : keypad rows, active-low, asynchronous
//   col_out     : one-cold column drive
//   col_oeb     : active-low column output enable
//   key_code    : accepted key {row, col}
//   key_valid   : key_code holds an unconsumed key
//   key_ready   : consumer accept
//   key_overrun : pulse when an accepted key was dropped (register full)
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_TICKS     = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            en,
  input  logic [ROWS-1:0] row_in,
  output logic [COLS-1:0] col_out,
  output logic [COLS-1:0] col_oeb,
  output key_code_t       key_code,
  output logic            key_valid,
  input  logic            key_ready,
  output logic            key_overrun
);

  localparam int TW = $clog2(SCAN_TICKS);
  localparam int SW = $clog2(DEBOUNCE_SCANS+1);
  localparam logic [TW-1:0] TC_LAST = TW'(SCAN_TICKS-1);
  localparam logic [SW-1:0] SC_LAST = SW'(DEBOUNCE_SCANS-1);

  logic [ROWS-1:0] rs;

  sync2 #(.WIDTH(ROWS)) u_sync (
    .clk  (clk),
    .nrst (nrst),
    .d    (row_in),
    .q    (rs)
  );

  state_t          state, state_nxt;
  logic [1:0]      col, col_nxt;
  logic [TW-1:0]   tc, tc_nxt;
  logic [SW-1:0]   sc, sc_nxt;
  key_code_t       cand, cand_nxt;
  logic            sample, load, cand_low;

  logic [COLS-1:0] col_out_nxt, col_oeb_nxt;
  key_code_t       code_nxt;
  logic            valid_nxt, ovr_nxt;

  assign sample   = (tc == TC_LAST);
  assign cand_low = ~rs[cand[3:2]];

  // State register (FSM state, counters, candidate, registered outputs)
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state       <= SCAN;
      col         <= '0;
      tc          <= '0;
      sc          <= '0;
      cand        <= '0;
      col_out     <= '1;
      col_oeb     <= '1;
      key_code    <= '0;
      key_valid   <= 1'b0;
      key_overrun <= 1'b0;
    end else begin
      state       <= state_nxt;
      col         <= col_nxt;
      tc          <= tc_nxt;
      sc          <= sc_nxt;
      cand        <= cand_nxt;
      col_out     <= col_out_nxt;
      col_oeb     <= col_oeb_nxt;
      key_code    <= code_nxt;
      key_valid   <= valid_nxt;
      key_overrun <= ovr_nxt;
    end
  end

  // Next-state logic. Every sample ends a tick window, so tc restarts there
  // regardless of whether the column or state moves.
  always_comb begin
    state_nxt = state;
    col_nxt   = col;
    sc_nxt    = sc;
    cand_nxt  = cand;
    load      = 1'b0;
    tc_nxt    = sample ? '0 : tc + 1'b1;
    if (!en) begin
      state_nxt = SCAN;
      col_nxt   = '0;
      sc_nxt    = '0;
      tc_nxt    = '0;
    end else if (sample) begin
      case (state)
        SCAN: begin
          if (rs != '1) begin
            cand_nxt  = {low_row(rs), col};
            sc_nxt    = '0;
            state_nxt = DEBOUNCE;
          end else begin
            col_nxt = col + 1'b1;
          end
        end
        DEBOUNCE: begin
          if (cand_low) begin
            if (sc == SC_LAST) begin
              load      = 1'b1;
              sc_nxt    = '0;          // RELEASE counts highs from zero
              state_nxt = RELEASE;
            end else begin
              sc_nxt = sc + 1'b1;
            end
          end else begin
            state_nxt = SCAN;
            col_nxt   = col + 1'b1;
          end
        end
        RELEASE: begin
          if (!cand_low) begin
            if (sc == SC_LAST) begin
              sc_nxt    = '0;
              state_nxt = SCAN;
              col_nxt   = col + 1'b1;
            end else begin
              sc_nxt = sc + 1'b1;
            end
          end else begin
            sc_nxt = '0;
          end
        end
        default: state_nxt = SCAN;
      endcase
    end
  end

  // Output logic. Column drive follows the registered column, so each
  // column value is presented for a full tick window.
  always_comb begin
    col_out_nxt = '1;
    col_oeb_nxt = '1;
    code_nxt    = key_code;
    valid_nxt   = 1'b0;
    ovr_nxt     = 1'b0;
    if (en) begin
      col_out_nxt = ~(COLS'(1) << col);
      col_oeb_nxt = '0;
      valid_nxt   = key_valid;
      if (load && (!key_valid || key_ready)) begin
        code_nxt  = cand;
        valid_nxt = 1'b1;
      end else if (load) begin
        ovr_nxt = 1'b1;
      end else if (key_valid && key_ready) begin
        valid_nxt = 1'b0;
      end
    end
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 matrix keypad wired to breakout GPIOs, debounces presses and releases, and hands one 4-bit key code at a time to the team core logic over a valid/ready handshake. Sits directly upstream of the team top-level core: its column outputs and column output-enables are routed to `gpio_out`/`gpio_oeb` bits, and its row inputs come from `gpio_in` bits. It produces one code per physical press, with no auto-repeat.

## Interface
- `SCAN_TICKS`, default 1000: clock cycles each column is driven; must be ≥ 4.
- `DEBOUNCE_SCANS`, default 4: consecutive agreeing samples needed to accept a press or a release; must be ≥ 1.
- `clk`  in  1  system clock.
- `nrst`  in  1  reset, asynchronous, active-low.
- `en`  in  1  block enable; low means the block is idle and its outputs are tri-stated.
- `row_in`  in  4  keypad rows, active-low with external pull-ups, asynchronous to `clk`.
- `col_out`  out  4  column drive, one-cold (driven column = 0).
- `col_oeb`  out  4  active-low output enable for the columns.
- `key_code`  out  4  accepted key, {row[1:0], col[1:0]}.
- `key_valid`  out  1  `key_code` holds an unconsumed key.
- `key_ready`  in  1  consumer accepts the key when `key_valid && key_ready`.
- `key_overrun`  out  1  one-cycle pulse: a key was accepted while the holding register was full, and that key was dropped.

## Operation
- `row_in` passes through a 2-FF synchronizer. All decisions use the synchronized rows `rs`.
- Tick counter `tc` counts 0..SCAN_TICKS-1, and a sample occurs on the cycle `tc == SCAN_TICKS-1`. `tc` resets to 0 on every column change and on every state change.
- States:
  - SCAN
    - Drive column `col`.
    - At a sample with no row low: `col <= col+1`, wrapping 3 -> 0.
    - At a sample with any row low: take the lowest-index low row, capture `cand = {row, col}`, clear the stable count `sc`, and go to DEBOUNCE. The column is held.
  - DEBOUNCE
    - At each sample, if `rs[cand.row]` is still low, `sc++`.
    - When `sc` reaches DEBOUNCE_SCANS: load the holding register and go to RELEASE.
    - If `rs[cand.row]` is high at a sample: go to SCAN with `col <= col+1`. No key is produced.
  - RELEASE
    - Hold `col`.
    - At each sample, `rs[cand.row]` high increments `sc`; low clears `sc` to 0.
    - When `sc` reaches DEBOUNCE_SCANS: go to SCAN with `col <= col+1`.
- Holding register load:
  - If `key_valid` is 0, or `key_valid && key_ready` in the same cycle (the load wins): `key_code <= cand` and `key_valid <= 1`.
  - Otherwise `key_code` and `key_valid` are unchanged and `key_overrun` pulses for 1 cycle.
- `key_valid` clears the cycle after `key_valid && key_ready` when no load happens in that cycle.
- `en` low is a synchronous clear:
  - state = SCAN, `col` = 0, `tc` = `sc` = 0.
  - `key_valid` = 0, `key_overrun` = 0.
  - `col_out` = 4'b1111, `col_oeb` = 4'b1111.
  - When `en` rises, scanning restarts at column 0.
- When `en` is high, `col_oeb` = 4'b0000 and `col_out` = ~(1 << col).

## Timing
- Reset values:
  - `col_out` = 4'b1111, `col_oeb` = 4'b1111.
  - `key_code` = 0, `key_valid` = 0, `key_overrun` = 0.
  - Internally: state SCAN, `col` = 0, `tc` = `sc` = 0, synchronizer FFs = 1.
- Outputs are registered. On the first edge with `nrst` = 1 and `en` = 1, `col_out` becomes 4'b1110 and `col_oeb` becomes 4'b0000.
- Row-to-decision latency is 2 cycles. `SCAN_TICKS` ≥ 4 guarantees that a sample sees settled rows for the driven column.
- Press latency: `key_valid` rises DEBOUNCE_SCANS×SCAN_TICKS cycles after the detecting sample, on the edge after the final good sample.
- `key_overrun` and a lost handshake never coexist in one cycle.
- `nrst` asserted mid-operation forces reset values immediately, with no clock required.

## Structure
- Package `keypad_pkg`:
  - `state_t` enum {SCAN, DEBOUNCE, RELEASE}.
  - `key_code_t` (logic [3:0]).
  - Constants `ROWS` = 4 and `COLS` = 4.
- Sub-module `sync2`: a parameterized-width 2-FF synchronizer that resets to 1, instantiated at width 4 for the rows.
- Counter widths: `$clog2(SCAN_TICKS)` for `tc` and `$clog2(DEBOUNCE_SCANS+1)` for `sc`.

## Test plan
All scenarios use SCAN_TICKS=4, DEBOUNCE_SCANS=2, `en`=1 and rows idle at 4'hF unless noted.
- **Reset and scan sequence:** hold `nrst`=0 -> all outputs are at reset values. Release `nrst` -> `col_out` steps 1110, 1101, 1011, 0111, then wraps to 1110, with each value lasting 4 cycles.
- **Clean press:** hold row 2 low while column 1 is driven, long enough to finish debounce -> `key_code`=4'd9 and `key_valid`=1 exactly 8 cycles after the detecting sample. `key_valid` holds until `key_ready`. Keeping the key pressed produces no second key. Releasing it resumes scanning at column 2.
- **Bounce:** row 0 is low for one sample on column 3, then high -> `key_valid` stays 0 and the next column driven is 0.
- **Overrun:** with `key_ready`=0, press and release key 9, then press key 3 -> `key_code` stays 9, `key_valid` stays 1, and `key_overrun` pulses for exactly 1 cycle.
- **Simultaneous handshake:** `key_ready`=1 in the cycle key 3 loads while key 9 is still valid -> `key_code`=3, `key_valid`=1, and no overrun.
- **Enable and reset mid-operation:**
  - Drop `en` during DEBOUNCE -> next cycle `col_oeb`=1111, `col_out`=1111 and `key_valid`=0. Raising `en` restarts the scan at column 0.
  - Assert `nrst` asynchronously between clock edges -> outputs reach reset values before the next edge.
